alu_ctrl_fsm: RTL and testbench
===============================

// Module: alu_ctrl_fsm
// PURPOSE
//  Multicycle control unit driving the datapath ALU: decodes the latched 32-bit instruction,
//  sequences FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK, issues alu_control and consumes alu_flags.
//  Holds the NZCV flag register and evaluates condition codes to gate architectural writes.
//  Sits between instruction memory/IR and the register file, ALU and data memory.
// PARAMETERS
//  ALU_CTRL_W  4       width of alu_control (matches ALU opcode field)
//  FLAG_W      4       width of flag bus, order {N,Z,C,V}
//  RESET_FLAGS 4'b0000 flag-register value after reset
// PORTS
//  clk          in   1   single clock, all state on rising edge
//  reset        in   1   synchronous, active-high
//  instr        in   32  IR contents; cond[31:28] op[27:26] I[25] cmd[24:21] S/L[20] sh[6:5]
//  alu_flags    in   4   ALU {N,Z,C,V} for the operation currently issued
//  mem_ready    in   1   memory access completes this cycle
//  alu_control  out  4   0000 ADD,0001 SUB,0010 MUL,0011 SRL,0100 SLL,0101 SRA
//  alu_src_a    out  2   00 reg Rn, 01 PC, 10 ALUOut
//  alu_src_b    out  2   00 reg, 01 extended imm, 10 const 4
//  imm_src      out  2   00 imm8 DP, 01 imm12 mem, 10 imm24 branch
//  result_src   out  2   00 ALUOut, 01 mem data, 10 ALU result
//  adr_src      out  1   0 PC, 1 ALUOut
//  ir_write     out  1   load IR
//  pc_write     out  1   update PC
//  reg_write    out  1   write Rd
//  mem_write    out  1   store to data memory
//  flags_q      out  4   current flag register
//  illegal      out  1   one-cycle pulse on undefined op/cmd
// BEHAVIOUR
//  Reset: state FETCH, flags_q=RESET_FLAGS; all write strobes, illegal =0; alu_control=0000.
//  States: FETCH, DECODE, EXEC_R, EXEC_I, MEM_ADR, MEM_RD, MEM_WB, MEM_WR, ALU_WB, BRANCH.
//  FETCH: adr_src=0, alu_src_a=01, alu_src_b=10, ADD; ir_write=pc_write=mem_ready; stay until mem_ready.
//  DECODE: computes PC+4 again (ADD); op 00->EXEC_R(I=0)/EXEC_I(I=1), 01->MEM_ADR,
//   10->BRANCH, 11->FETCH with illegal=1.
//  EXEC_R/EXEC_I: cmd 0100 ADD, 0010 SUB, 1010 CMP(SUB), 0001 MUL, 1101 shift by sh:
//   00 SLL, 01 SRL, 10 SRA, 11 illegal. Next ALU_WB; CMP or illegal -> FETCH.
//  Flag write: at the EXEC_R/EXEC_I edge, flags_q<=alu_flags iff cond passes and (S=1 or CMP).
//  ALU_WB: result_src=00, reg_write=cond_ex; next FETCH.
//  MEM_ADR: alu_src_b=01, imm_src=01, ADD; L=1 -> MEM_RD, L=0 -> MEM_WR.
//  MEM_RD: adr_src=1; hold until mem_ready, then MEM_WB. MEM_WB: result_src=01, reg_write=cond_ex.
//  MEM_WR: adr_src=1, mem_write=cond_ex while waiting; leave to FETCH on mem_ready.
//  BRANCH: alu_src_a=10, imm_src=10, alu_src_b=01, ADD, result_src=10, pc_write=cond_ex; next FETCH.
//  cond_ex from flags_q (pre-update): EQ Z, NE !Z, CS C, CC !C, MI N, PL !N, VS V, VC !V,
//   HI C&!Z, LS !C|Z, GE N==V, LT N!=V, GT !Z&(N==V), LE Z|(N!=V), AL 1, 1111 never.
//  Failed cond: FSM still walks full path; only reg_write/mem_write/pc_write(non-FETCH)/flag write suppressed.
//  Latency (mem_ready=1): DP 4 cycles, CMP 3, LDR 5, STR 4, B 3. Each stalled cycle adds one.
//  Reset mid-instruction: next edge FETCH, no partial writes issued in reset cycle.
//  All outputs combinational from state+instr+flags_q (Moore for sequencing, cond gating only).
// STRUCTURE
//  Package alu_ctrl_pkg: state enum, ALU opcode constants, cmd/op/cond encodings, flag bit indices.
//  Sub-module cond_unit: flag register + cond_ex evaluation (inputs cond, flags, flag_we).
//  Top: state register, next-state logic, output decode.
// TESTING
//  reset held 2 cycles mid MEM_RD -> FETCH, flags_q=0000, all strobes 0 during reset.
//  ADDS (cond=AL,S=1), ALU flags 0100, mem_ready=1 -> 4 cycles, reg_write in cycle 4, flags_q=0100.
//  CMP then BEQ: CMP gives Z=1 -> BRANCH pc_write=1; repeat with Z=0 -> pc_write=0, still 3 cycles.
//  LDR with mem_ready low 3 cycles in MEM_RD -> 8 cycles total, reg_write single cycle in MEM_WB.
//  STRNE with Z=1 -> mem_write never asserted, FSM returns to FETCH after MEM_WR.
//  op=11 and cmd=1101 sh=11 -> illegal pulses exactly one cycle, no reg/flag write.

Source files
------------

// File: rtl/alu_ctrl_pkg.sv
// Shared encodings for the multicycle ALU control unit: FSM states,
// instruction field layout, ALU opcodes, datapath mux selects, flag
// bit positions and condition-code evaluation.
package alu_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_EXEC_R,
    S_EXEC_I,
    S_MEM_ADR,
    S_MEM_RD,
    S_MEM_WB,
    S_MEM_WR,
    S_ALU_WB,
    S_BRANCH
  } state_t;

  // IR field layout, MSB first
  typedef struct packed {
    logic [3:0]  cond;
    logic [1:0]  op;
    logic        i;
    logic [3:0]  cmd;
    logic        s;     // S for data processing, L for memory ops
    logic [12:0] rsvd_hi;
    logic [1:0]  sh;
    logic [4:0]  rsvd_lo;
  } instr_t;

  // ALU opcodes
  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b0001;
  localparam logic [3:0] ALU_MUL = 4'b0010;
  localparam logic [3:0] ALU_SRL = 4'b0011;
  localparam logic [3:0] ALU_SLL = 4'b0100;
  localparam logic [3:0] ALU_SRA = 4'b0101;

  // op field
  localparam logic [1:0] OP_DP    = 2'b00;
  localparam logic [1:0] OP_MEM   = 2'b01;
  localparam logic [1:0] OP_BR    = 2'b10;

  // cmd field
  localparam logic [3:0] CMD_ADD   = 4'b0100;
  localparam logic [3:0] CMD_SUB   = 4'b0010;
  localparam logic [3:0] CMD_CMP   = 4'b1010;
  localparam logic [3:0] CMD_MUL   = 4'b0001;
  localparam logic [3:0] CMD_SHIFT = 4'b1101;

  // shift type
  localparam logic [1:0] SH_SLL = 2'b00;
  localparam logic [1:0] SH_SRL = 2'b01;
  localparam logic [1:0] SH_SRA = 2'b10;

  // mux selects
  localparam logic [1:0] SRCA_REG  = 2'b00;
  localparam logic [1:0] SRCA_PC   = 2'b01;
  localparam logic [1:0] SRCA_ALUO = 2'b10;
  localparam logic [1:0] SRCB_REG  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_4    = 2'b10;
  localparam logic [1:0] IMM_DP8   = 2'b00;
  localparam logic [1:0] IMM_MEM12 = 2'b01;
  localparam logic [1:0] IMM_BR24  = 2'b10;
  localparam logic [1:0] RES_ALUO  = 2'b00;
  localparam logic [1:0] RES_MEM   = 2'b01;
  localparam logic [1:0] RES_ALU   = 2'b10;

  // condition codes
  localparam logic [3:0] COND_EQ = 4'h0;
  localparam logic [3:0] COND_NE = 4'h1;
  localparam logic [3:0] COND_CS = 4'h2;
  localparam logic [3:0] COND_CC = 4'h3;
  localparam logic [3:0] COND_MI = 4'h4;
  localparam logic [3:0] COND_PL = 4'h5;
  localparam logic [3:0] COND_VS = 4'h6;
  localparam logic [3:0] COND_VC = 4'h7;
  localparam logic [3:0] COND_HI = 4'h8;
  localparam logic [3:0] COND_LS = 4'h9;
  localparam logic [3:0] COND_GE = 4'hA;
  localparam logic [3:0] COND_LT = 4'hB;
  localparam logic [3:0] COND_GT = 4'hC;
  localparam logic [3:0] COND_LE = 4'hD;
  localparam logic [3:0] COND_AL = 4'hE;

  // flag bit indices within {N,Z,C,V}
  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  // condition pass/fail against a flag snapshot
  function automatic logic cond_eval(input logic [3:0] cond, input logic [3:0] f);
    logic n, z, c, v;
    n = f[FLAG_N];
    z = f[FLAG_Z];
    c = f[FLAG_C];
    v = f[FLAG_V];
    case (cond)
      COND_EQ: cond_eval = z;
      COND_NE: cond_eval = !z;
      COND_CS: cond_eval = c;
      COND_CC: cond_eval = !c;
      COND_MI: cond_eval = n;
      COND_PL: cond_eval = !n;
      COND_VS: cond_eval = v;
      COND_VC: cond_eval = !v;
      COND_HI: cond_eval = c && !z;
      COND_LS: cond_eval = !c || z;
      COND_GE: cond_eval = (n == v);
      COND_LT: cond_eval = (n != v);
      COND_GT: cond_eval = !z && (n == v);
      COND_LE: cond_eval = z || (n != v);
      COND_AL: cond_eval = 1'b1;
      default: cond_eval = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/alu_ctrl_fsm_cond_unit.sv
// NZCV flag register plus condition evaluation. The pass/fail result is
// captured when the instruction leaves DECODE so that writeback gating
// keeps seeing the pre-update flags even after an S-suffixed EXEC edge
// has rewritten the flag register.
module cond_unit
  import alu_ctrl_pkg::*;
#(
  parameter int                FLAG_W      = 4,
  parameter logic [FLAG_W-1:0] RESET_FLAGS = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [3:0]        cond,
  input  logic [FLAG_W-1:0] flags,
  input  logic              flag_we,
  input  logic              cond_ld,
  output logic [FLAG_W-1:0] flags_q,
  output logic              cond_ex
);

  logic cond_live;
  logic cond_q;

  assign cond_live = cond_eval(cond, flags_q);

  // flag register, loaded from the ALU on a qualified EXEC edge
  always_ff @(posedge clk) begin
    if (reset)        flags_q <= RESET_FLAGS;
    else if (flag_we) flags_q <= flags;
  end

  // condition result frozen at the DECODE edge for the rest of the instruction
  always_ff @(posedge clk) begin
    if (reset)        cond_q <= 1'b0;
    else if (cond_ld) cond_q <= cond_live;
  end

  assign cond_ex = cond_q;

endmodule

// File: rtl/alu_ctrl_fsm.sv
// Multicycle control unit: sequences fetch/decode/execute/memory/writeback,
// drives ALU and datapath mux selects, and gates architectural writes with
// the instruction's condition code.
module alu_ctrl_fsm
  import alu_ctrl_pkg::*;
#(
  parameter int                ALU_CTRL_W  = 4,
  parameter int                FLAG_W      = 4,
  parameter logic [FLAG_W-1:0] RESET_FLAGS = '0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [31:0]           instr,
  input  logic [FLAG_W-1:0]     alu_flags,
  input  logic                  mem_ready,
  output logic [ALU_CTRL_W-1:0] alu_control,
  output logic [1:0]            alu_src_a,
  output logic [1:0]            alu_src_b,
  output logic [1:0]            imm_src,
  output logic [1:0]            result_src,
  output logic                  adr_src,
  output logic                  ir_write,
  output logic                  pc_write,
  output logic                  reg_write,
  output logic                  mem_write,
  output logic [FLAG_W-1:0]     flags_q,
  output logic                  illegal
);

  instr_t     ir;
  state_t     state, state_nx;
  logic       cond_ex;
  logic       flag_we;
  logic       cond_ld;
  logic       cmd_ok;
  logic       is_cmp;
  logic [3:0] dp_op;
  logic [3:0] alu_op;

  assign ir = instr_t'(instr);

  cond_unit #(
    .FLAG_W      (FLAG_W),
    .RESET_FLAGS (RESET_FLAGS)
  ) u_cond (
    .clk     (clk),
    .reset   (reset),
    .cond    (ir.cond),
    .flags   (alu_flags),
    .flag_we (flag_we),
    .cond_ld (cond_ld),
    .flags_q (flags_q),
    .cond_ex (cond_ex)
  );

  // data-processing cmd/sh to ALU opcode; flags unknown encodings
  always_comb begin
    dp_op  = ALU_ADD;
    cmd_ok = 1'b1;
    is_cmp = 1'b0;
    case (ir.cmd)
      CMD_ADD: dp_op = ALU_ADD;
      CMD_SUB: dp_op = ALU_SUB;
      CMD_CMP: begin
        dp_op  = ALU_SUB;
        is_cmp = 1'b1;
      end
      CMD_MUL: dp_op = ALU_MUL;
      CMD_SHIFT: begin
        case (ir.sh)
          SH_SLL:  dp_op = ALU_SLL;
          SH_SRL:  dp_op = ALU_SRL;
          SH_SRA:  dp_op = ALU_SRA;
          default: cmd_ok = 1'b0;
        endcase
      end
      default: cmd_ok = 1'b0;
    endcase
  end

  // state register
  always_ff @(posedge clk) begin
    if (reset) state <= S_FETCH;
    else       state <= state_nx;
  end

  // next state and output decode; reset forces every output to idle
  always_comb begin
    state_nx   = state;
    alu_op     = ALU_ADD;
    alu_src_a  = SRCA_REG;
    alu_src_b  = SRCB_REG;
    imm_src    = IMM_DP8;
    result_src = RES_ALUO;
    adr_src    = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    reg_write  = 1'b0;
    mem_write  = 1'b0;
    illegal    = 1'b0;
    flag_we    = 1'b0;
    cond_ld    = 1'b0;
    case (state)
      S_FETCH: begin
        alu_src_a = SRCA_PC;
        alu_src_b = SRCB_4;
        ir_write  = mem_ready;
        pc_write  = mem_ready;
        if (mem_ready) state_nx = S_DECODE;
      end
      S_DECODE: begin
        alu_src_a = SRCA_PC;
        alu_src_b = SRCB_4;
        cond_ld   = 1'b1;
        case (ir.op)
          OP_DP:   state_nx = ir.i ? S_EXEC_I : S_EXEC_R;
          OP_MEM:  state_nx = S_MEM_ADR;
          OP_BR:   state_nx = S_BRANCH;
          default: begin
            state_nx = S_FETCH;
            illegal  = 1'b1;
          end
        endcase
      end
      S_EXEC_R, S_EXEC_I: begin
        alu_op    = dp_op;
        alu_src_b = (state == S_EXEC_I) ? SRCB_IMM : SRCB_REG;
        illegal   = !cmd_ok;
        flag_we   = cmd_ok && cond_ex && (ir.s || is_cmp);
        state_nx  = (is_cmp || !cmd_ok) ? S_FETCH : S_ALU_WB;
      end
      S_ALU_WB: begin
        result_src = RES_ALUO;
        reg_write  = cond_ex;
        state_nx   = S_FETCH;
      end
      S_MEM_ADR: begin
        alu_src_b = SRCB_IMM;
        imm_src   = IMM_MEM12;
        state_nx  = ir.s ? S_MEM_RD : S_MEM_WR;
      end
      S_MEM_RD: begin
        adr_src = 1'b1;
        if (mem_ready) state_nx = S_MEM_WB;
      end
      S_MEM_WB: begin
        result_src = RES_MEM;
        reg_write  = cond_ex;
        state_nx   = S_FETCH;
      end
      S_MEM_WR: begin
        adr_src   = 1'b1;
        mem_write = cond_ex;
        if (mem_ready) state_nx = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a  = SRCA_ALUO;
        alu_src_b  = SRCB_IMM;
        imm_src    = IMM_BR24;
        result_src = RES_ALU;
        pc_write   = cond_ex;
        state_nx   = S_FETCH;
      end
      default: state_nx = S_FETCH;
    endcase
    if (reset) begin
      alu_op    = ALU_ADD;
      ir_write  = 1'b0;
      pc_write  = 1'b0;
      reg_write = 1'b0;
      mem_write = 1'b0;
      illegal   = 1'b0;
      flag_we   = 1'b0;
      cond_ld   = 1'b0;
    end
  end

  assign alu_control = ALU_CTRL_W'(alu_op);

endmodule

// File: tb/tb_alu_ctrl_fsm.sv
// Randomized self-checking bench: each instruction is run with a planned
// mem_ready schedule and checked against a per-instruction outcome model
// (length, strobe counts/positions, ALU op, resulting flags).
module tb_alu_ctrl_fsm;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] instr;
  logic [3:0]  alu_flags;
  logic        mem_ready;
  logic [3:0]  alu_control;
  logic [1:0]  alu_src_a, alu_src_b, imm_src, result_src;
  logic        adr_src, ir_write, pc_write, reg_write, mem_write, illegal;
  logic [3:0]  flags_q;

  int total = 0;
  int bad   = 0;
  logic [3:0] m_flags;

  alu_ctrl_fsm #(.ALU_CTRL_W(4), .FLAG_W(4), .RESET_FLAGS(4'b0000)) dut (
    .clk(clk), .reset(reset), .instr(instr), .alu_flags(alu_flags),
    .mem_ready(mem_ready), .alu_control(alu_control), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .imm_src(imm_src), .result_src(result_src),
    .adr_src(adr_src), .ir_write(ir_write), .pc_write(pc_write),
    .reg_write(reg_write), .mem_write(mem_write), .flags_q(flags_q),
    .illegal(illegal)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // ARM-style: base test selected by cond[3:1], inverted by cond[0]
  function automatic logic cond_ok(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cy, v, b;
    {n, z, cy, v} = f;
    case (c[3:1])
      3'd0: b = z;
      3'd1: b = cy;
      3'd2: b = n;
      3'd3: b = v;
      3'd4: b = cy & ~z;
      3'd5: b = (n == v);
      3'd6: b = ~z & (n == v);
      default: b = 1'b1;
    endcase
    return (c == 4'hF) ? 1'b0 : (b ^ c[0]);
  endfunction

  function automatic logic [31:0] mk(input logic [3:0] cond, input logic [1:0] op,
                                     input logic i, input logic [3:0] cmd,
                                     input logic s, input logic [1:0] sh);
    logic [31:0] r;
    r = $urandom;
    r[31:28] = cond; r[27:26] = op; r[25] = i; r[24:21] = cmd; r[20] = s; r[6:5] = sh;
    return r;
  endfunction

  task automatic run(input logic [31:0] ins, input int fs, input int ms, input logic [3:0] exf);
    logic [1:0] op, sh;
    logic [3:0] cmd, eop, g_op;
    logic sb, pass, legal, cmp;
    int len, rw_idx, pc_idx, pc_cnt, mw_cnt, ill_idx;
    int g_ir_cnt, g_ir_idx, g_pc_cnt, g_pc_idx, g_rw_cnt, g_rw_idx, g_mw_cnt, g_ill_cnt, g_ill_idx;
    op = ins[27:26]; cmd = ins[24:21]; sh = ins[6:5]; sb = ins[20];
    pass = cond_ok(ins[31:28], m_flags);
    legal = 1'b1; cmp = 1'b0; eop = 4'd0;
    case (cmd)
      4'b0100: eop = 4'd0;
      4'b0010: eop = 4'd1;
      4'b1010: begin eop = 4'd1; cmp = 1'b1; end
      4'b0001: eop = 4'd2;
      4'b1101: if (sh == 2'd0) eop = 4'd4; else if (sh == 2'd1) eop = 4'd3;
               else if (sh == 2'd2) eop = 4'd5; else legal = 1'b0;
      default: legal = 1'b0;
    endcase
    rw_idx = -1; pc_idx = fs; pc_cnt = 1; mw_cnt = 0; ill_idx = -1;
    case (op)
      2'd0: if (!legal) begin len = fs + 3; ill_idx = fs + 2; end
            else if (cmp) len = fs + 3;
            else begin len = fs + 4; if (pass) rw_idx = fs + 3; end
      2'd1: if (sb) begin len = fs + 5 + ms; if (pass) rw_idx = len - 1; end
            else begin len = fs + 4 + ms; if (pass) mw_cnt = ms + 1; end
      2'd2: begin len = fs + 3; if (pass) begin pc_idx = fs + 2; pc_cnt = 2; end end
      default: begin len = fs + 2; ill_idx = fs + 1; end
    endcase
    g_ir_cnt = 0; g_ir_idx = -1; g_pc_cnt = 0; g_pc_idx = -1; g_rw_cnt = 0; g_rw_idx = -1;
    g_mw_cnt = 0; g_ill_cnt = 0; g_ill_idx = -1; g_op = 4'hF;
    instr = ins;
    for (int k = 0; k < len; k++) begin
      if (k <= fs) mem_ready = (k == fs);
      else if (op == 2'd1 && k >= fs + 3) mem_ready = (k == fs + 3 + ms);
      else mem_ready = 1'($urandom);
      alu_flags = (k == fs + 2) ? exf : 4'($urandom);
      @(negedge clk);
      if (ir_write)  begin g_ir_cnt++;  g_ir_idx = k;  end
      if (pc_write)  begin g_pc_cnt++;  g_pc_idx = k;  end
      if (reg_write) begin g_rw_cnt++;  g_rw_idx = k;  end
      if (mem_write) g_mw_cnt++;
      if (illegal)   begin g_ill_cnt++; g_ill_idx = k; end
      if (k == fs + 2) g_op = alu_control;
      @(posedge clk); #1;
    end
    if (op == 2'd0 && legal && pass && (sb || cmp)) m_flags = exf;
    chk("ir_cnt", g_ir_cnt, 1);
    chk("ir_idx", g_ir_idx, fs);
    chk("pc_cnt", g_pc_cnt, pc_cnt);
    chk("pc_idx", g_pc_idx, pc_idx);
    chk("rw_cnt", g_rw_cnt, (rw_idx >= 0) ? 1 : 0);
    chk("rw_idx", g_rw_idx, rw_idx);
    chk("mw_cnt", g_mw_cnt, mw_cnt);
    chk("ill_cnt", g_ill_cnt, (ill_idx >= 0) ? 1 : 0);
    chk("ill_idx", g_ill_idx, ill_idx);
    if (op == 2'd0 && legal) chk("alu_op", g_op, eop);
    chk("flags", flags_q, m_flags);
  endtask

  // start a memory op, then hold reset for two cycles once it reaches the access state
  task automatic reset_mid(input logic [31:0] ins);
    instr = ins;
    for (int k = 0; k < 5; k++) begin
      mem_ready = (k == 0) ? 1'b1 : (k >= 3) ? 1'b0 : 1'($urandom);
      reset = (k >= 3);
      alu_flags = 4'($urandom);
      @(negedge clk);
      if (k >= 3) begin
        chk("rst_strobes", {ir_write, pc_write, reg_write, mem_write, illegal}, 5'b0);
        chk("rst_aluctl", alu_control, 4'b0000);
      end
      @(posedge clk); #1;
    end
    reset = 1'b0;
    m_flags = 4'b0000;
    chk("rst_flags", flags_q, 4'b0000);
  endtask

  initial begin
    logic [1:0] op, sh;
    logic [3:0] cmd;
    logic [3:0] cmds [5];
    int r;
    cmds[0] = 4'b0100; cmds[1] = 4'b0010; cmds[2] = 4'b1010; cmds[3] = 4'b0001; cmds[4] = 4'b1101;
    reset = 1'b1; instr = '0; alu_flags = '0; mem_ready = 1'b0;
    m_flags = 4'b0000;
    repeat (2) begin
      @(negedge clk);
      chk("por_strobes", {ir_write, pc_write, reg_write, mem_write, illegal}, 5'b0);
      chk("por_flags", flags_q, 4'b0000);
      chk("por_aluctl", alu_control, 4'b0000);
      @(posedge clk); #1;
    end
    reset = 1'b0;

    // ADDS AL, ALU reports Z
    run(mk(4'hE, 2'b00, 1'b0, 4'b0100, 1'b1, 2'b00), 0, 0, 4'b0100);
    // LDR, reset held two cycles while waiting in MEM_RD
    reset_mid(mk(4'hE, 2'b01, 1'b0, 4'b0000, 1'b1, 2'b00));
    // CMP Z=1 then BEQ taken; CMP Z=0 then BEQ not taken
    run(mk(4'hE, 2'b00, 1'b0, 4'b1010, 1'b0, 2'b00), 0, 0, 4'b0100);
    run(mk(4'h0, 2'b10, 1'b0, 4'b0000, 1'b0, 2'b00), 0, 0, 4'b0000);
    run(mk(4'hE, 2'b00, 1'b1, 4'b1010, 1'b0, 2'b00), 0, 0, 4'b0000);
    run(mk(4'h0, 2'b10, 1'b0, 4'b0000, 1'b0, 2'b00), 0, 0, 4'b0000);
    // LDR with three stalled memory cycles
    run(mk(4'hE, 2'b01, 1'b0, 4'b0000, 1'b1, 2'b00), 0, 3, 4'b0000);
    // STRNE with Z set, and a STR interrupted by reset in MEM_WR
    run(mk(4'hE, 2'b00, 1'b0, 4'b1010, 1'b0, 2'b00), 0, 0, 4'b0110);
    run(mk(4'h1, 2'b01, 1'b0, 4'b0000, 1'b0, 2'b00), 1, 2, 4'b0000);
    run(mk(4'hE, 2'b00, 1'b0, 4'b1010, 1'b0, 2'b00), 0, 0, 4'b1001);
    reset_mid(mk(4'hE, 2'b01, 1'b0, 4'b0000, 1'b0, 2'b00));
    // undefined op and undefined shift, both with S set
    run(mk(4'hE, 2'b11, 1'b0, 4'b0100, 1'b1, 2'b00), 0, 0, 4'b1111);
    run(mk(4'hE, 2'b00, 1'b0, 4'b1101, 1'b1, 2'b11), 0, 0, 4'b1111);
    // S-flagged conditional add: writeback gated by pre-update flags
    run(mk(4'h0, 2'b00, 1'b0, 4'b0100, 1'b1, 2'b00), 0, 0, 4'b1111);
    run(mk(4'h1, 2'b00, 1'b0, 4'b0100, 1'b1, 2'b00), 0, 0, 4'b0100);

    for (int n = 0; n < 200; n++) begin
      r = $urandom_range(0, 15);
      op = (r < 6) ? 2'b00 : (r < 10) ? 2'b01 : (r < 14) ? 2'b10 : 2'b11;
      cmd = ($urandom_range(0, 7) == 0) ? 4'($urandom) : cmds[$urandom_range(0, 4)];
      sh = 2'($urandom);
      run(mk(4'($urandom), op, 1'($urandom), cmd, 1'($urandom), sh),
          $urandom_range(0, 2), $urandom_range(0, 3), 4'($urandom));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
